score_keeper: RTL and testbench
===============================

# score_keeper

Match-score controller for the Pong game. Accepts point pulses from the ball/paddle logic for both players and serialises them into two 2-digit BCD score registers, at most one increment per cycle. It detects the winning score, freezes play until a new game is requested, and time-multiplexes the four score digits onto a shared 7-segment digit bus.

## Interface
- WIN_SCORE, 8'h11: winning score, packed BCD (tens in [7:4], ones in [3:0]); valid range 8'h01..8'h99, both nibbles ≤ 9.
- SCAN_DIV, 1024: clock cycles each digit stays selected; must be ≥ 2.

- clock  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high.
- point_l  in  1  one-cycle pulse: left player scored.
- point_r  in  1  one-cycle pulse: right player scored.
- new_game  in  1  one-cycle pulse: clear scores and resume play.
- score_l  out  8  left score, packed BCD.
- score_r  out  8  right score, packed BCD.
- game_over  out  1  high while the match is decided.
- winner  out  1  0 = left, 1 = right; valid only while game_over = 1.
- digit_sel  out  4  one-hot digit enable: bit0 = left tens, bit1 = left ones, bit2 = right tens, bit3 = right ones.
- digit_val  out  4  BCD value of the selected digit.

## Operation
- Reset values:
  - score_l = score_r = 8'h00.
  - game_over = 0, winner = 0.
  - pend_l = pend_r = 0.
  - State = PLAY.
  - Scan index = 0, so digit_sel = 4'b0001; divider = 0.
- Pending latches:
  - point_x high at an edge sets pend_x, unless the same edge clears pend_x through service, new_game or OVER.
  - A second pulse arriving while pend_x is already set merges with it; it does not add a second point.
- FSM states: PLAY, CHECK, OVER.
  - PLAY, pend_l = 1: increment score_l, clear pend_l, go to CHECK.
  - PLAY, pend_l = 0 and pend_r = 1: increment score_r, clear pend_r, go to CHECK.
  - PLAY, neither pending: stay in PLAY.
  - Left has fixed priority, so simultaneous points give left first and right one service slot later.
  - CHECK: if score_l == WIN_SCORE, set game_over = 1, winner = 0, go to OVER.
  - CHECK: else if score_r == WIN_SCORE, set game_over = 1, winner = 1, go to OVER.
  - CHECK: otherwise return to PLAY.
  - OVER: point_l/point_r are ignored and pend_l/pend_r are held at 0.
- BCD increment:
  - Ones nibble 9 → 0 with carry into tens.
  - 8'h99 saturates at 8'h99; no wrap to 00.
  - Nibbles never hold values A–F.
- new_game, sampled in any state:
  - Clears scores, pendings, game_over and winner; next state is PLAY.
  - Has priority over any coincident or pending point; those points are discarded.
  - Does not disturb the scan divider or scan index.
- Display scan:
  - Divider counts 0..SCAN_DIV-1.
  - On the edge where the divider is at SCAN_DIV-1, the divider returns to 0 and the index advances 0 → 1 → 2 → 3 → 0.
  - digit_sel = 1 << index (registered).
  - digit_val is combinational from the index and the current scores: 0 = score_l[7:4], 1 = score_l[3:0], 2 = score_r[7:4], 3 = score_r[3:0].
- Reset mid-operation: all state returns to reset values on the next edge, regardless of FSM state or pending points.

## Timing
- Single point, edge N (state PLAY, nothing pending):
  - point_l sampled at N sets pend_l.
  - score_l updated at edge N+1.
  - Win check at N+2; game_over rises after N+2 if the score reached WIN_SCORE.
- Simultaneous point_l and point_r at edge N:
  - score_l updates at N+1, CHECK at N+2.
  - score_r updates at N+3, CHECK at N+4.
  - If left wins at N+2, the pending right point is discarded.
- Sustained throughput: one point per 2 cycles.
- new_game at edge N: all outputs except digit_sel show cleared values after N.
- Each digit stays selected for exactly SCAN_DIV cycles; a full four-digit frame is 4·SCAN_DIV cycles.

## Test plan
- Reset, then idle 10 cycles → scores 8'h00, game_over = 0, digit_sel = 4'b0001, digit_val = 0.
- 10 point_l pulses spaced 4 cycles apart (WIN_SCORE = 8'h11) → score_l steps 01..09, then 8'h10; the ones nibble never shows A.
  - An 11th pulse → score_l = 8'h11, and game_over = 1, winner = 0 two cycles after that pulse.
- point_l and point_r in the same cycle at 8'h05 / 8'h07 → score_l = 8'h06 one cycle after sampling; score_r = 8'h08 two cycles later.
- With game_over = 1: point_r pulse → scores unchanged. Then new_game → scores 8'h00, game_over = 0, and pend_r stays clear.
- new_game coincident with point_l at score 8'h03 → score_l = 8'h00 and no increment follows.
- SCAN_DIV = 4, score_l = 8'h12, score_r = 8'h07 → digit_sel sequence 0001/0010/0100/1000, each for 4 cycles, with digit_val = 1, 2, 0, 7; assert reset mid-frame → digit_sel = 0001 on the next edge.

Source files
------------

// File: rtl/score_keeper_if.sv
// Point/new-game strobes and score/display outputs of the Pong score keeper.
interface score_keeper_if;
    logic       point_l;
    logic       point_r;
    logic       new_game;
    logic [7:0] score_l;
    logic [7:0] score_r;
    logic       game_over;
    logic       winner;
    logic [3:0] digit_sel;
    logic [3:0] digit_val;

    modport master (
        output point_l, point_r, new_game,
        input  score_l, score_r, game_over, winner, digit_sel, digit_val
    );

    modport slave (
        input  point_l, point_r, new_game,
        output score_l, score_r, game_over, winner, digit_sel, digit_val
    );
endinterface

// File: rtl/score_keeper.sv
// Pong match-score controller: serialises point pulses into two BCD scores,
// detects the win, and scans the four score digits onto a shared digit bus.
module score_keeper #(
    parameter logic [7:0] WIN_SCORE = 8'h11,
    parameter int         SCAN_DIV  = 1024
) (
    input  logic          clock,
    input  logic          reset,
    score_keeper_if.slave bus
);
    localparam int DIV_W = $clog2(SCAN_DIV);

    typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

    state_t           state, state_next;
    logic             pend_l, pend_r;
    logic [7:0]       score_l, score_r;
    logic             game_over, winner;
    logic [DIV_W-1:0] div;
    logic [1:0]       idx;
    logic [3:0]       digit_sel;
    logic [3:0]       digit_val;
    logic             inc_l, inc_r, win_l, win_r;

    // Saturating packed-BCD increment; nibbles stay within 0..9.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v == 8'h99)
            return 8'h99;
        if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_ff @(posedge clock) begin
        if (reset)
            state <= PLAY;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            PLAY:    if (inc_l || inc_r) state_next = CHECK;
            CHECK:   state_next = (win_l || win_r) ? OVER : PLAY;
            OVER:    state_next = OVER;
            default: state_next = PLAY;
        endcase
        if (bus.new_game)
            state_next = PLAY;
    end

    // Left has fixed priority when both players have a point waiting.
    always_comb begin
        inc_l = (state == PLAY) && pend_l;
        inc_r = (state == PLAY) && !pend_l && pend_r;
        win_l = (state == CHECK) && (score_l == WIN_SCORE);
        win_r = (state == CHECK) && (score_l != WIN_SCORE) && (score_r == WIN_SCORE);
    end

    always_ff @(posedge clock) begin
        if (reset || bus.new_game) begin
            score_l   <= 8'h00;
            score_r   <= 8'h00;
            pend_l    <= 1'b0;
            pend_r    <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
        end else begin
            if (inc_l)
                score_l <= bcd_inc(score_l);
            if (inc_r)
                score_r <= bcd_inc(score_r);
            // A pulse landing on the service edge merges into the point being served.
            pend_l <= (state == OVER || inc_l) ? 1'b0 : (pend_l | bus.point_l);
            pend_r <= (state == OVER || inc_r) ? 1'b0 : (pend_r | bus.point_r);
            if (win_l || win_r) begin
                game_over <= 1'b1;
                winner    <= win_r;
            end
        end
    end

    // Display scan runs independently of new_game.
    always_ff @(posedge clock) begin
        if (reset) begin
            div       <= '0;
            idx       <= 2'd0;
            digit_sel <= 4'b0001;
        end else if (div == DIV_W'(SCAN_DIV - 1)) begin
            div       <= '0;
            idx       <= idx + 2'd1;
            digit_sel <= {digit_sel[2:0], digit_sel[3]};
        end else begin
            div <= div + 1'b1;
        end
    end

    always_comb begin
        case (idx)
            2'd0:    digit_val = score_l[7:4];
            2'd1:    digit_val = score_l[3:0];
            2'd2:    digit_val = score_r[7:4];
            default: digit_val = score_r[3:0];
        endcase
    end

    assign bus.score_l   = score_l;
    assign bus.score_r   = score_r;
    assign bus.game_over = game_over;
    assign bus.winner    = winner;
    assign bus.digit_sel = digit_sel;
    assign bus.digit_val = digit_val;
endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus randomized
// point traffic compared against an integer-score reference model.
module tb_score_keeper;
    localparam int SCAN   = 4;
    localparam int WIN_DEC = 11;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_fail;

    score_keeper_if bus ();
    score_keeper_if bus2 ();

    score_keeper #(.WIN_SCORE(8'h11), .SCAN_DIV(SCAN)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance with an unreachable win score, used for the display scan.
    score_keeper #(.WIN_SCORE(8'h99), .SCAN_DIV(SCAN)) u_dut2 (
        .clock (clock),
        .reset (reset),
        .bus   (bus2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: scores as plain integers, points waiting as flags.
    int m_l, m_r, m_div, m_idx;
    bit m_pl, m_pr, m_chk, m_over, m_win;

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic void model_step(input bit pl, input bit pr, input bit ng, input bit rst);
        bit svc_l, svc_r;
        if (rst) begin
            m_l = 0; m_r = 0; m_div = 0; m_idx = 0;
            m_pl = 0; m_pr = 0; m_chk = 0; m_over = 0; m_win = 0;
            return;
        end
        if (m_div == SCAN - 1) begin
            m_div = 0;
            m_idx = (m_idx + 1) % 4;
        end else begin
            m_div = m_div + 1;
        end
        if (ng) begin
            m_l = 0; m_r = 0; m_pl = 0; m_pr = 0; m_chk = 0; m_over = 0; m_win = 0;
            return;
        end
        if (m_over) begin
            m_pl = 0; m_pr = 0;
            return;
        end
        svc_l = 0; svc_r = 0;
        if (m_chk) begin
            m_chk = 0;
            if (m_l == WIN_DEC) begin m_over = 1; m_win = 0; end
            else if (m_r == WIN_DEC) begin m_over = 1; m_win = 1; end
        end else if (m_pl) begin
            m_l = (m_l < 99) ? m_l + 1 : 99; svc_l = 1; m_chk = 1;
        end else if (m_pr) begin
            m_r = (m_r < 99) ? m_r + 1 : 99; svc_r = 1; m_chk = 1;
        end
        m_pl = !svc_l && (m_pl || pl);
        m_pr = !svc_r && (m_pr || pr);
    endfunction

    task automatic tick(input bit pl, input bit pr, input bit ng);
        bus.point_l = pl; bus.point_r = pr; bus.new_game = ng;
        @(posedge clock);
        model_step(pl, pr, ng, reset);
        @(negedge clock);
        bus.point_l = 0; bus.point_r = 0; bus.new_game = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0);
    endtask

    task automatic test_reset;
        reset = 1;
        tick(0, 0, 0);
        n_cmp++; if (bus.score_l !== 8'h00) begin n_fail++; $display("FAIL reset_score_l got=%h exp=00", bus.score_l); end
        n_cmp++; if (bus.score_r !== 8'h00) begin n_fail++; $display("FAIL reset_score_r got=%h exp=00", bus.score_r); end
        n_cmp++; if (bus.game_over !== 1'b0 || bus.winner !== 1'b0) begin n_fail++; $display("FAIL reset_over got=%b/%b exp=0/0", bus.game_over, bus.winner); end
        n_cmp++; if (bus.digit_sel !== 4'b0001) begin n_fail++; $display("FAIL reset_digit_sel got=%b exp=0001", bus.digit_sel); end
        n_cmp++; if (bus.digit_val !== 4'd0) begin n_fail++; $display("FAIL reset_digit_val got=%h exp=0", bus.digit_val); end
        reset = 0;
        idle(10);
        n_cmp++; if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00) begin n_fail++; $display("FAIL idle_scores got=%h/%h exp=00/00", bus.score_l, bus.score_r); end
        n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL idle_over got=%b exp=0", bus.game_over); end
        n_cmp++; if (bus.digit_sel !== 4'(1 << m_idx) || bus.digit_val !== 4'd0) begin n_fail++; $display("FAIL idle_digit got=%b/%h exp=%b/0", bus.digit_sel, bus.digit_val, 4'(1 << m_idx)); end
    endtask

    task automatic test_count_to_win;
        for (int i = 1; i <= 10; i++) begin
            tick(1, 0, 0);
            idle(3);
            n_cmp++; if (bus.score_l !== to_bcd(i) || bus.score_l[3:0] > 4'd9) begin n_fail++; $display("FAIL count_score_l[%0d] got=%h exp=%h", i, bus.score_l, to_bcd(i)); end
            n_cmp++; if (bus.game_over !== 1'b0) begin n_fail++; $display("FAIL count_over[%0d] got=%b exp=0", i, bus.game_over); end
        end
        tick(1, 0, 0);
        tick(0, 0, 0);
        n_cmp++; if (bus.score_l !== 8'h11 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL win_score got=%h/%b exp=11/0", bus.score_l, bus.game_over); end
        tick(0, 0, 0);
        n_cmp++; if (bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin n_fail++; $display("FAIL win_flag got=%b/%b exp=1/0", bus.game_over, bus.winner); end
    endtask

    task automatic test_over_ignore;
        tick(0, 1, 0);
        idle(4);
        n_cmp++; if (bus.score_l !== 8'h11 || bus.score_r !== 8'h00 || bus.game_over !== 1'b1) begin n_fail++; $display("FAIL over_ignore got=%h/%h/%b exp=11/00/1", bus.score_l, bus.score_r, bus.game_over); end
        tick(0, 0, 1);
        n_cmp++; if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL over_newgame got=%h/%h/%b exp=00/00/0", bus.score_l, bus.score_r, bus.game_over); end
        idle(4);
        n_cmp++; if (bus.score_r !== 8'h00 || bus.score_l !== 8'h00) begin n_fail++; $display("FAIL over_no_pend got=%h/%h exp=00/00", bus.score_l, bus.score_r); end
    endtask

    task automatic test_simultaneous;
        for (int i = 0; i < 5; i++) begin tick(1, 0, 0); tick(0, 0, 0); end
        for (int i = 0; i < 7; i++) begin tick(0, 1, 0); tick(0, 0, 0); end
        idle(2);
        n_cmp++; if (bus.score_l !== 8'h05 || bus.score_r !== 8'h07) begin n_fail++; $display("FAIL simul_setup got=%h/%h exp=05/07", bus.score_l, bus.score_r); end
        tick(1, 1, 0);
        tick(0, 0, 0);
        n_cmp++; if (bus.score_l !== 8'h06 || bus.score_r !== 8'h07) begin n_fail++; $display("FAIL simul_left got=%h/%h exp=06/07", bus.score_l, bus.score_r); end
        idle(2);
        n_cmp++; if (bus.score_l !== 8'h06 || bus.score_r !== 8'h08) begin n_fail++; $display("FAIL simul_right got=%h/%h exp=06/08", bus.score_l, bus.score_r); end
    endtask

    task automatic test_newgame_coincident;
        tick(0, 0, 1);
        for (int i = 0; i < 3; i++) begin tick(1, 0, 0); tick(0, 0, 0); end
        idle(2);
        n_cmp++; if (bus.score_l !== 8'h03) begin n_fail++; $display("FAIL ng_setup got=%h exp=03", bus.score_l); end
        tick(1, 0, 1);
        n_cmp++; if (bus.score_l !== 8'h00 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL ng_clear got=%h/%b exp=00/0", bus.score_l, bus.game_over); end
        idle(4);
        n_cmp++; if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00) begin n_fail++; $display("FAIL ng_no_inc got=%h/%h exp=00/00", bus.score_l, bus.score_r); end
    endtask

    task automatic test_scan;
        logic [3:0] ev [4];
        logic [3:0] es;
        int guard;
        ev[0] = 4'd1; ev[1] = 4'd2; ev[2] = 4'd0; ev[3] = 4'd7;
        for (int i = 0; i < 12; i++) begin bus2.point_l = 1; tick(0, 0, 0); bus2.point_l = 0; tick(0, 0, 0); end
        for (int i = 0; i < 7; i++) begin bus2.point_r = 1; tick(0, 0, 0); bus2.point_r = 0; tick(0, 0, 0); end
        idle(2);
        n_cmp++; if (bus2.score_l !== 8'h12 || bus2.score_r !== 8'h07 || bus2.game_over !== 1'b0) begin n_fail++; $display("FAIL scan_setup got=%h/%h/%b exp=12/07/0", bus2.score_l, bus2.score_r, bus2.game_over); end
        guard = 0;
        while (!(m_idx == 0 && m_div == 0) && guard < 32) begin tick(0, 0, 0); guard++; end
        n_cmp++; if (guard >= 32) begin n_fail++; $display("FAIL scan_align got=%0d cycles exp<32", guard); end
        for (int d = 0; d < 4; d++) begin
            es = 4'b0001 << d;
            for (int c = 0; c < SCAN; c++) begin
                n_cmp++; if (bus2.digit_sel !== es || bus2.digit_val !== ev[d]) begin n_fail++; $display("FAIL scan[%0d.%0d] got=%b/%h exp=%b/%h", d, c, bus2.digit_sel, bus2.digit_val, es, ev[d]); end
                tick(0, 0, 0);
            end
        end
        idle(2);
        reset = 1;
        tick(0, 0, 0);
        reset = 0;
        n_cmp++; if (bus2.digit_sel !== 4'b0001 || bus.digit_sel !== 4'b0001) begin n_fail++; $display("FAIL scan_reset got=%b/%b exp=0001/0001", bus2.digit_sel, bus.digit_sel); end
        n_cmp++; if (bus2.score_l !== 8'h00 || bus2.score_r !== 8'h00) begin n_fail++; $display("FAIL scan_reset_scores got=%h/%h exp=00/00", bus2.score_l, bus2.score_r); end
    endtask

    task automatic test_reset_mid;
        tick(1, 1, 0);
        reset = 1;
        tick(0, 0, 0);
        reset = 0;
        idle(4);
        n_cmp++; if (bus.score_l !== 8'h00 || bus.score_r !== 8'h00 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL reset_mid got=%h/%h/%b exp=00/00/0", bus.score_l, bus.score_r, bus.game_over); end
    endtask

    task automatic test_random;
        bit pl, pr, ng;
        logic [3:0] dv;
        tick(0, 0, 1);
        for (int i = 0; i < 1500; i++) begin
            pl = ($urandom_range(0, 2) == 0);
            pr = ($urandom_range(0, 2) == 0);
            ng = ($urandom_range(0, 199) == 0);
            tick(pl, pr, ng);
            case (m_idx)
                0:       dv = 4'(m_l / 10);
                1:       dv = 4'(m_l % 10);
                2:       dv = 4'(m_r / 10);
                default: dv = 4'(m_r % 10);
            endcase
            n_cmp++; if (bus.score_l !== to_bcd(m_l) || bus.score_r !== to_bcd(m_r)) begin n_fail++; $display("FAIL rand_scores[%0d] got=%h/%h exp=%h/%h", i, bus.score_l, bus.score_r, to_bcd(m_l), to_bcd(m_r)); end
            n_cmp++; if (bus.game_over !== m_over || (m_over && bus.winner !== m_win)) begin n_fail++; $display("FAIL rand_over[%0d] got=%b/%b exp=%b/%b", i, bus.game_over, bus.winner, m_over, m_win); end
            n_cmp++; if (bus.digit_sel !== 4'(1 << m_idx) || bus.digit_val !== dv) begin n_fail++; $display("FAIL rand_digit[%0d] got=%b/%h exp=%b/%h", i, bus.digit_sel, bus.digit_val, 4'(1 << m_idx), dv); end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        reset = 1;
        bus.point_l = 0; bus.point_r = 0; bus.new_game = 0;
        bus2.point_l = 0; bus2.point_r = 0; bus2.new_game = 0;
        model_step(0, 0, 0, 1);
        @(negedge clock);
        test_reset;
        test_count_to_win;
        test_over_ignore;
        test_simultaneous;
        test_newgame_coincident;
        test_scan;
        test_reset_mid;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
